vedic_32bits_seq: RTL and testbench

- Multi-cycle 32x32 unsigned multiplier controller.
- Time-shares a single vedic_16bits core across the four half-word partial products (lo*lo, hi*lo, lo*hi, hi*hi) and accumulates the shifted results into a 64-bit product.
- Serves area-constrained paths where the fully parallel four-core vedic_32bits cost is not justified.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/vedic_pkg.sv | 17 +
 rtl/vedic_16bits.sv | 17 +
 rtl/vedic_32bits_seq.sv | 127 ++++++++++++
 tb/tb_vedic_32bits_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared types and constants for the vedic multiplier family.
package vedic_pkg;

  localparam int unsigned STEP_W = 2;
  localparam int unsigned SH_W   = 6;

  localparam logic [SH_W-1:0] SH_LO  = 6'd0;
  localparam logic [SH_W-1:0] SH_MID = 6'd16;
  localparam logic [SH_W-1:0] SH_HI  = 6'd32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vedic_16bits.sv
// Combinational 16x16 unsigned multiplier built from four 8x8 vertical/crosswise partials.
module vedic_16bits (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);

  logic [15:0] ll, hl, lh, hh;

  assign ll = 16'(a_i[7:0])  * 16'(b_i[7:0]);
  assign hl = 16'(a_i[15:8]) * 16'(b_i[7:0]);
  assign lh = 16'(a_i[7:0])  * 16'(b_i[15:8]);
  assign hh = 16'(a_i[15:8]) * 16'(b_i[15:8]);

  assign p_o = 32'(ll) + (32'(hl) << 8) + (32'(lh) << 8) + (32'(hh) << 16);

endmodule

// File: rtl/vedic_32bits_seq.sv
// 32x32 unsigned multiplier that time-shares one vedic_16bits core over four steps,
// with valid/ready handshakes on operands and product.
module vedic_32bits_seq
  import vedic_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic [2*WIDTH-1:0] Q,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               BUSY
);

  localparam int unsigned HALF   = WIDTH / 2;
  localparam int unsigned PROD_W = 2 * WIDTH;

  state_e              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [PROD_W-1:0]   acc_q, q_q;
  logic                out_valid_q, busy_q;

  logic [HALF-1:0]     core_a_c, core_b_c;
  logic [WIDTH-1:0]    core_p_c;
  logic [SH_W-1:0]     sh_c;
  logic [PROD_W-1:0]   pp_c;
  logic                accept_c;

  // Ready depends on OUT_READY only, never on IN_VALID.
  assign IN_READY  = (state_q == IDLE) || ((state_q == DONE) && OUT_READY);
  assign accept_c  = IN_READY && IN_VALID;
  assign Q         = q_q;
  assign OUT_VALID = out_valid_q;
  assign BUSY      = busy_q;

  // Half-word operand and shift selection per step.
  always_comb begin
    core_a_c = a_q[HALF-1:0];
    core_b_c = b_q[HALF-1:0];
    sh_c     = SH_LO;
    case (step_q)
      2'd1: begin
        core_a_c = a_q[WIDTH-1:HALF];
        sh_c     = SH_MID;
      end
      2'd2: begin
        core_b_c = b_q[WIDTH-1:HALF];
        sh_c     = SH_MID;
      end
      2'd3: begin
        core_a_c = a_q[WIDTH-1:HALF];
        core_b_c = b_q[WIDTH-1:HALF];
        sh_c     = SH_HI;
      end
      default: ;
    endcase
  end

  vedic_16bits u_core (
    .a_i (core_a_c),
    .b_i (core_b_c),
    .p_o (core_p_c)
  );

  assign pp_c = PROD_W'(core_p_c) << sh_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      step_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      q_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            a_q     <= A;
            b_q     <= B;
            acc_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: begin
          if (step_q == 2'd3) begin
            q_q         <= acc_q + pp_c;
            step_q      <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            acc_q  <= acc_q + pp_c;
            step_q <= step_q + 2'd1;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            if (accept_c) begin
              a_q     <= A;
              b_q     <= B;
              acc_q   <= '0;
              step_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= MUL;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_32bits_seq.sv
// Directed bench for vedic_32bits_seq: vector table plus handshake corner sequences.
module tb_vedic_32bits_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] A, B;
  logic        IN_VALID, IN_READY;
  logic [63:0] Q;
  logic        OUT_VALID, OUT_READY, BUSY;

  int n_total = 0;
  int n_pass  = 0;

  vedic_32bits_seq #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .Q         (Q),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    bit          scr;
    string       name;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Waits (bounded) for OUT_VALID; returns cycles after the accept edge, 99 on timeout.
  task automatic wait_valid(input bit scr, output int lat, output int busy_cnt);
    bit seen = 1'b0;
    lat = 99;
    busy_cnt = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      if (BUSY) busy_cnt++;
      if (scr) begin
        A = $urandom;
        B = $urandom;
      end
      @(posedge CLK); #1;
      if (OUT_VALID) begin
        seen = 1'b1;
        lat  = i;
      end
    end
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit scr, input string nm);
    int lat, bc;
    A = a; B = b; IN_VALID = 1'b1; OUT_READY = 1'b1;
    chk({nm, " in_ready"}, 64'(IN_READY), 64'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    wait_valid(scr, lat, bc);
    chk({nm, " latency"}, 64'(lat), 64'd4);
    chk({nm, " q"}, Q, exp);
    chk({nm, " busy_cycles"}, 64'(bc), 64'd4);
    @(posedge CLK); #1;
    chk({nm, " out_valid_drop"}, 64'(OUT_VALID), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, bc, bad;
    RST = 1'b1; IN_VALID = 1'b0; A = '0; B = '0; OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst busy", 64'(BUSY), 64'd0);
    chk("rst q", Q, 64'd0);
    chk("rst in_ready", 64'(IN_READY), 64'd1);
    RST = 1'b0;
    @(posedge CLK); #1;

    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0, "ones"};
    vecs[1] = '{32'h0000FFFF, 32'h00010001, 64'h00000000FFFFFFFF, 1'b0, "cross1"};
    vecs[2] = '{32'h00010000, 32'h00010000, 64'h0000000100000000, 1'b0, "cross2"};
    vecs[3] = '{32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000, 1'b0, "zero"};
    vecs[4] = '{32'h12345678, 32'h00000001, 64'h0000000012345678, 1'b0, "ident"};
    vecs[5] = '{32'h00010000, 32'h0000FFFF, 64'h00000000FFFF0000, 1'b0, "hi_lo"};
    vecs[6] = '{32'hDEADBEEF, 32'h00000002, 64'h00000001BD5B7DDE, 1'b0, "dbeef"};
    vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b1, "isolate"};
    vecs[8] = '{32'h0000FFFF, 32'h00010001, 64'h00000000FFFFFFFF, 1'b1, "isolate2"};

    for (int i = 0; i < 9; i++)
      do_mul(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].scr, vecs[i].name);

    // Backpressure: product must hold while OUT_READY is low.
    A = 32'h80000000; B = 32'd2; IN_VALID = 1'b1; OUT_READY = 1'b0;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    wait_valid(1'b0, lat, bc);
    chk("bp latency", 64'(lat), 64'd4);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (OUT_VALID !== 1'b1 || Q !== 64'h0000000100000000 || IN_READY !== 1'b0) bad++;
      @(posedge CLK); #1;
    end
    chk("bp hold cycles_bad", 64'(bad), 64'd0);
    chk("bp q", Q, 64'h0000000100000000);
    OUT_READY = 1'b1; #1;
    chk("bp release in_ready", 64'(IN_READY), 64'd1);
    @(posedge CLK); #1;
    chk("bp release out_valid", 64'(OUT_VALID), 64'd0);
    chk("bp q held after handshake", Q, 64'h0000000100000000);

    // Back-to-back: second operand pair accepted in the DONE cycle.
    A = 32'd3; B = 32'd5; IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(posedge CLK); #1;
    A = 32'd7; B = 32'd11;
    wait_valid(1'b0, lat, bc);
    chk("b2b first latency", 64'(lat), 64'd4);
    chk("b2b first q", Q, 64'd15);
    chk("b2b in_ready in done", 64'(IN_READY), 64'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    chk("b2b busy after reaccept", 64'(BUSY), 64'd1);
    chk("b2b out_valid dropped", 64'(OUT_VALID), 64'd0);
    chk("b2b q held", Q, 64'd15);
    wait_valid(1'b0, lat, bc);
    chk("b2b second spacing", 64'(lat + 1), 64'd4 + 64'd1);
    chk("b2b second q", Q, 64'd77);
    @(posedge CLK); #1;

    // Reset during step 2 of a multiply.
    A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    chk("midrst busy before", 64'(BUSY), 64'd1);
    RST = 1'b1; #1;
    chk("midrst busy", 64'(BUSY), 64'd0);
    chk("midrst out_valid", 64'(OUT_VALID), 64'd0);
    chk("midrst q", Q, 64'd0);
    chk("midrst in_ready", 64'(IN_READY), 64'd1);
    @(posedge CLK); #1;
    RST = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) bad++;
    end
    chk("midrst no stray valid", 64'(bad), 64'd0);
    do_mul(32'd6, 32'd7, 64'd42, 1'b0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
